rst_gen: RTL and testbench

//   Reset sequencer and lock monitor that consumes the MMCM lock output in clk_rst.

---
 rtl/rst_gen.sv | 120 ++++++++++++
 tb/tb_rst_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rst_gen.sv
// Lock-qualified reset sequencer: releases o_rst, then o_rst_hash.
// Optional lock-loss counter built when RST_LOST_CNT_EN is defined.
module rst_gen #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int HASH_DELAY         = 256
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_mmcm_locked,
  output logic       o_rst,
  output logic       o_rst_hash,
  output logic       o_ready,
  output logic       o_lock_lost,
  output logic [7:0] o_lost_cnt
);

  localparam int MAXC =
    (LOCK_STABLE_CYCLES > HASH_DELAY) ?
    LOCK_STABLE_CYCLES : HASH_DELAY;
  localparam int CW = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] LOCK_LAST =
    CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HASH_LAST =
    CW'(HASH_DELAY - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    REL_SYS,
    RUN
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;

  // Plain flop chain; LOCKED is asynchronous to i_clk.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_mmcm_locked};
    end
  end

  assign lock_s = sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      o_rst       <= 1'b1;
      o_rst_hash  <= 1'b1;
      o_ready     <= 1'b0;
      o_lock_lost <= 1'b0;
    end else begin
      o_lock_lost <= 1'b0;
      unique case (state)
        WAIT_LOCK: begin
          if (!lock_s) begin
            cnt <= '0;
          end else if (cnt == LOCK_LAST) begin
            state <= REL_SYS;
            cnt   <= '0;
            o_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REL_SYS: begin
          // Lock loss wins over the hash release.
          if (!lock_s) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            o_rst       <= 1'b1;
            o_rst_hash  <= 1'b1;
            o_ready     <= 1'b0;
            o_lock_lost <= 1'b1;
          end else if (cnt == HASH_LAST) begin
            state      <= RUN;
            o_rst_hash <= 1'b0;
            o_ready    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            o_rst       <= 1'b1;
            o_rst_hash  <= 1'b1;
            o_ready     <= 1'b0;
            o_lock_lost <= 1'b1;
          end
        end
        default: begin
          state <= WAIT_LOCK;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef RST_LOST_CNT_EN
  // Counts registered pulses, so it lags o_lock_lost by one edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_lost_cnt <= 8'd0;
    end else if (o_lock_lost && (o_lost_cnt != 8'hff)) begin
      o_lost_cnt <= o_lost_cnt + 8'd1;
    end
  end
`else
  assign o_lost_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_rst_gen.sv
// Bench for rst_gen: directed scenarios plus random lock traffic,
// checked each edge against a phase/run-length reference model.
module tb_rst_gen;

  localparam int SS  = 2;
  localparam int LSC = 16;
  localparam int HD  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       locked = 1'b0;
  logic       o_rst;
  logic       o_rst_hash;
  logic       o_ready;
  logic       o_lock_lost;
  logic [7:0] o_lost_cnt;

  int vectors = 0;
  int miscompares = 0;

  rst_gen #(
    .SYNC_STAGES       (SS),
    .LOCK_STABLE_CYCLES(LSC),
    .HASH_DELAY        (HD)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_mmcm_locked(locked),
    .o_rst        (o_rst),
    .o_rst_hash   (o_rst_hash),
    .o_ready      (o_ready),
    .o_lock_lost  (o_lock_lost),
    .o_lost_cnt   (o_lost_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: delay line for the synchronizer,
  // phase 0 = qualifying, 1 = system released, 2 = running.
  bit mq[$];
  int phase = 0;
  int n = 0;
  bit m_lost = 1'b0;
  int m_cnt = 0;

  task automatic model(input bit r, input bit lk);
    bit ls;
    if (r) begin
      mq.delete();
      for (int i = 0; i < SS; i++) mq.push_back(1'b0);
      phase  = 0;
      n      = 0;
      m_lost = 1'b0;
      m_cnt  = 0;
    end else begin
      ls = mq.pop_front();
      mq.push_back(lk);
      if (m_lost && m_cnt < 255) m_cnt++;
      m_lost = 1'b0;
      if (phase == 0) begin
        if (ls) begin
          n++;
          if (n == LSC) begin
            phase = 1;
            n = 0;
          end
        end else begin
          n = 0;
        end
      end else if (!ls) begin
        phase  = 0;
        n      = 0;
        m_lost = 1'b1;
      end else if (phase == 1) begin
        n++;
        if (n == HD) phase = 2;
      end
    end
  endtask

  function automatic logic [7:0] exp_cnt();
`ifdef RST_LOST_CNT_EN
    return 8'(m_cnt);
`else
    return 8'd0;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit lk);
    @(negedge clk);
    rst    = r;
    locked = lk;
    @(posedge clk);
    model(r, lk);
    #1;
    chk("o_rst", 8'(o_rst), 8'(phase == 0));
    chk("o_rst_hash", 8'(o_rst_hash), 8'(phase != 2));
    chk("o_ready", 8'(o_ready), 8'(phase == 2));
    chk("o_lock_lost", 8'(o_lock_lost), 8'(m_lost));
    chk("o_lost_cnt", o_lost_cnt, exp_cnt());
  endtask

  task automatic hold(input bit lk, input int k);
    for (int i = 0; i < k; i++) step(1'b0, lk);
  endtask

  initial begin
    int guard;
    int pulses;

    // Reset state
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("rst_state_rst", 8'(o_rst), 8'd1);
    chk("rst_state_ready", 8'(o_ready), 8'd0);

    // 1: lock rises 5 cycles after reset release
    hold(1'b0, 5);
    hold(1'b1, 17);
    chk("lat1_rst_held", 8'(o_rst), 8'd1);
    step(1'b0, 1'b1);
    chk("lat1_rst_rel", 8'(o_rst), 8'd0);
    hold(1'b1, 7);
    chk("lat1_hash_held", 8'(o_rst_hash), 8'd1);
    step(1'b0, 1'b1);
    chk("lat1_hash_rel", 8'(o_rst_hash), 8'd0);
    chk("lat1_ready", 8'(o_ready), 8'd1);

    // 2: glitch during qualification, no pulse
    step(1'b1, 1'b0);
    hold(1'b0, 2);
    hold(1'b1, 10);
    step(1'b0, 1'b0);
    hold(1'b1, 17);
    chk("glitch_rst_held", 8'(o_rst), 8'd1);
    step(1'b0, 1'b1);
    chk("glitch_rst_rel", 8'(o_rst), 8'd0);
    hold(1'b1, 10);

    // 3: lock drop in RUN
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("drop_rst_still_low", 8'(o_rst), 8'd0);
    step(1'b0, 1'b0);
    chk("drop_rst", 8'(o_rst), 8'd1);
    chk("drop_pulse", 8'(o_lock_lost), 8'd1);
    step(1'b0, 1'b1);
    chk("drop_pulse_end", 8'(o_lock_lost), 8'd0);
    hold(1'b1, 40);
    chk("relock_ready", 8'(o_ready), 8'd1);

    // 4: drop timed so loss lands on REL_SYS cnt==7
    step(1'b0, 1'b0);
    hold(1'b0, 3);
    guard = 0;
    while (phase != 1 && guard < 100) begin
      step(1'b0, 1'b1);
      guard++;
    end
    chk("relsys_reached", 8'(phase == 1), 8'd1);
    hold(1'b1, 5);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0);
      chk("relsys_hash_high", 8'(o_rst_hash), 8'd1);
      if (o_lock_lost) pulses++;
    end
    chk("relsys_one_pulse", 8'(pulses), 8'd1);

    // 5: i_rst in RUN with lock high
    hold(1'b1, 40);
    chk("run_before_rst", 8'(o_ready), 8'd1);
    step(1'b1, 1'b1);
    chk("mid_rst_rst", 8'(o_rst), 8'd1);
    chk("mid_rst_nopulse", 8'(o_lock_lost), 8'd0);
    hold(1'b1, 17);
    chk("mid_rst_held", 8'(o_rst), 8'd1);
    step(1'b0, 1'b1);
    chk("mid_rst_rel", 8'(o_rst), 8'd0);
    hold(1'b1, 10);

    // Random lock traffic with occasional resets
    for (int k = 0; k < 60; k++) begin
      hold(1'b1, $urandom_range(0, 40));
      hold(1'b0, $urandom_range(1, 4));
      if ($urandom_range(0, 9) == 0) step(1'b1, 1'($urandom));
    end

    // 6: many lock-loss events, then clear
    step(1'b1, 1'b0);
    for (int k = 0; k < 300; k++) begin
      hold(1'b1, 20 + $urandom_range(0, 3));
      hold(1'b0, 2);
    end
    hold(1'b0, 2);
`ifdef RST_LOST_CNT_EN
    chk("lost_cnt_sat", o_lost_cnt, 8'd255);
`else
    chk("lost_cnt_off", o_lost_cnt, 8'd0);
`endif
    step(1'b1, 1'b0);
    chk("lost_cnt_clr", o_lost_cnt, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
